// File: rtl/acc_rr_sched.sv
// acc_rr_sched: N requesters share one W-bit accumulate adder. A round-robin
// arbiter picks one requester per cycle and updates its private context; a
// flush pulse walks all contexts in ascending order, reading each out and
// zeroing it.
//
// Handshake: a requester raises req[i] with clr[i]/x slice i and holds all
// three stable until gnt[i]=1; the request is consumed in that same cycle and
// its result appears on out_* exactly one cycle later with out_valid=1.
module acc_rr_sched #(
   parameter int N  = 4,
   parameter int W  = 32,
   parameter int IW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   clr,
   input  logic [N*W-1:0] x,
   input  logic           flush,
   output logic [N-1:0]   gnt,
   output logic           out_valid,
   output logic [IW-1:0]  out_id,
   output logic [W-1:0]   out_q,
   output logic           out_flush,
   output logic           busy
);

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [IW-1:0] ptr;
   logic [IW-1:0] fc;
   logic [W-1:0]  ctx [N];
   logic [W-1:0]  x_arr [N];

   logic          gnt_any;
   logic [IW-1:0] gnt_idx;
   logic [W-1:0]  x_sel;
   logic [W-1:0]  new_val;

   // Split the packed operand bus into per-requester slices.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         x_arr[i] = x[i*W +: W];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: flush pulse enters FLUSH; the last context read returns to RUN.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (flush) state_nxt = FLUSH;
         FLUSH:   if (fc == IW'(N-1)) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // Outputs of the FSM: busy and the round-robin grant (first req at or after ptr).
   always_comb begin
      int idx;
      gnt     = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      busy    = (state == FLUSH);
      if (rst_n && state == RUN && !flush) begin
         for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_any && req[idx]) begin
               gnt_any = 1'b1;
               gnt_idx = IW'(idx);
            end
         end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
   end

   // Shared adder: load or accumulate the granted context, carry discarded.
   always_comb begin
      x_sel   = x_arr[gnt_idx];
      new_val = clr[gnt_idx] ? x_sel : (ctx[gnt_idx] + x_sel);
   end

   // Contexts, pointer, flush counter and the registered result port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) ctx[i] <= '0;
         ptr       <= '0;
         fc        <= '0;
         out_valid <= 1'b0;
         out_id    <= '0;
         out_q     <= '0;
         out_flush <= 1'b0;
      end else if (state == FLUSH) begin
         out_valid <= 1'b1;
         out_id    <= fc;
         out_q     <= ctx[fc];
         out_flush <= 1'b1;
         ctx[fc]   <= '0;
         fc        <= (fc == IW'(N-1)) ? '0 : fc + IW'(1);
      end else if (flush) begin
         // Entry cycle: no grant, pointer held, counter primed.
         out_valid <= 1'b0;
         fc        <= '0;
      end else if (gnt_any) begin
         ctx[gnt_idx] <= new_val;
         out_valid    <= 1'b1;
         out_id       <= gnt_idx;
         out_q        <= new_val;
         out_flush    <= 1'b0;
         ptr          <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + IW'(1);
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_acc_rr_sched.sv
// Directed bench for acc_rr_sched (N=4, W=32). Inputs change 1 ns after a
// rising edge, gnt is checked 1 ns later, registered outputs 1 ns after the
// following rising edge.
module tb_acc_rr_sched;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int IW = 2;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N-1:0]   clr;
   logic [N*W-1:0] x;
   logic           flush;
   logic [N-1:0]   gnt;
   logic           out_valid;
   logic [IW-1:0]  out_id;
   logic [W-1:0]   out_q;
   logic           out_flush;
   logic           busy;

   int n_checks = 0;
   int n_fail   = 0;

   acc_rr_sched #(.N(N), .W(W), .IW(IW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .clr(clr), .x(x), .flush(flush),
      .gnt(gnt), .out_valid(out_valid), .out_id(out_id), .out_q(out_q),
      .out_flush(out_flush), .busy(busy)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; clr = '0; x = '0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 4'b1111; clr = '0; x = '0; flush = 1'b0;
      #2;
      n_checks++;
      if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
      step();
      n_checks++;
      if ({out_valid, out_id, out_q, out_flush, busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_outs got v=%b id=%0d q=%h f=%b busy=%b exp all 0",
                  out_valid, out_id, out_q, out_flush, busy);
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_ptr0 got=%b exp=0001", gnt); end
      req = '0;
   endtask

   task automatic test_single();
      logic [W-1:0] acc;
      do_reset();
      acc = '0;
      for (int i = 0; i <= 1337; i++) begin
         req = 4'b0001; clr = '0; x[0 +: W] = W'(i);
         #1;
         n_checks++;
         if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt i=%0d got=%b exp=0001", i, gnt); end
         step();
         acc = acc + W'(i);
         n_checks++;
         if (out_valid !== 1'b1 || out_id !== 2'd0 || out_q !== acc || out_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL single_out i=%0d got v=%b id=%0d q=%0d exp v=1 id=0 q=%0d",
                     i, out_valid, out_id, out_q, acc);
         end
      end
      n_checks++;
      if (out_q !== 32'd894453) begin n_fail++; $display("FAIL single_total got=%0d exp=894453", out_q); end
      req = '0;
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_g;
      do_reset();
      req = 4'b1111; clr = '0;
      for (int i = 0; i < N; i++) x[i*W +: W] = W'(i + 1);
      for (int k = 0; k < 8; k++) begin
         #1;
         exp_g = 4'b0001 << (k % N);
         n_checks++;
         if (gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, gnt, exp_g); end
         step();
         n_checks++;
         if (out_valid !== 1'b1 || out_id !== IW'(k % N) || out_q !== W'((k / N + 1) * (k % N + 1))) begin
            n_fail++;
            $display("FAIL rr_out k=%0d got v=%b id=%0d q=%0d exp v=1 id=%0d q=%0d",
                     k, out_valid, out_id, out_q, k % N, (k / N + 1) * (k % N + 1));
         end
      end
      req = '0;
   endtask

   task automatic test_ptr_skip();
      do_reset();
      req = 4'b0010; x[1*W +: W] = 32'd1;
      step();
      req = 4'b1001;
      #1;
      n_checks++;
      if (gnt !== 4'b1000) begin n_fail++; $display("FAIL skip_first got=%b exp=1000", gnt); end
      step();
      #1;
      n_checks++;
      if (gnt !== 4'b0001) begin n_fail++; $display("FAIL skip_wrap got=%b exp=0001", gnt); end
      step();
      #1;
      n_checks++;
      if (gnt !== 4'b1000) begin n_fail++; $display("FAIL skip_ptr1 got=%b exp=1000", gnt); end
      req = '0;
      step();
   endtask

   task automatic test_load_wrap();
      do_reset();
      req = 4'b0010; clr = 4'b0010; x[1*W +: W] = 32'hFFFF_FFFE;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd1 || out_q !== 32'hFFFF_FFFE) begin
         n_fail++;
         $display("FAIL load_out got v=%b id=%0d q=%h exp v=1 id=1 q=fffffffe", out_valid, out_id, out_q);
      end
      clr = '0; x[1*W +: W] = 32'd3;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd1 || out_q !== 32'h0000_0001) begin
         n_fail++;
         $display("FAIL wrap_out got v=%b id=%0d q=%h exp v=1 id=1 q=00000001", out_valid, out_id, out_q);
      end
      req = '0;
      step();
   endtask

   task automatic test_flush();
      do_reset();
      req = 4'b1111; clr = 4'b1111;
      for (int i = 0; i < N; i++) x[i*W +: W] = W'(i + 5);
      repeat (N) step();
      clr = '0;
      for (int i = 0; i < N; i++) x[i*W +: W] = 32'd10;
      flush = 1'b1;
      #1;
      n_checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
         n_fail++; $display("FAIL flush_entry got gnt=%b busy=%b exp gnt=0000 busy=0", gnt, busy);
      end
      step();
      flush = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_entry_valid got=%b exp=0", out_valid); end
      for (int k = 0; k < N; k++) begin
         flush = (k == 1);
         #1;
         n_checks++;
         if (gnt !== 4'b0000 || busy !== 1'b1) begin
            n_fail++; $display("FAIL flush_busy k=%0d got gnt=%b busy=%b exp gnt=0000 busy=1", k, gnt, busy);
         end
         step();
         n_checks++;
         if (out_valid !== 1'b1 || out_id !== IW'(k) || out_q !== W'(k + 5) || out_flush !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_out k=%0d got v=%b id=%0d q=%0d f=%b exp v=1 id=%0d q=%0d f=1",
                     k, out_valid, out_id, out_q, out_flush, k, k + 5);
         end
      end
      flush = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         n_checks++;
         if (gnt !== (4'b0001 << k) || busy !== 1'b0) begin
            n_fail++; $display("FAIL resume_gnt k=%0d got gnt=%b busy=%b exp gnt=%b busy=0", k, gnt, busy, 4'b0001 << k);
         end
         step();
         n_checks++;
         if (out_valid !== 1'b1 || out_id !== IW'(k) || out_q !== 32'd10 || out_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL resume_out k=%0d got v=%b id=%0d q=%0d f=%b exp v=1 id=%0d q=10 f=0",
                     k, out_valid, out_id, out_q, out_flush, k);
         end
      end
      req = '0;
      step();
   endtask

   task automatic test_reset_mid_flush();
      do_reset();
      req = 4'b1000; clr = 4'b1000; x[3*W +: W] = 32'd100;
      step();
      req = '0; clr = '0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      repeat (2) step();
      n_checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd1 || out_flush !== 1'b1) begin
         n_fail++; $display("FAIL midflush_pre got v=%b id=%0d f=%b exp v=1 id=1 f=1", out_valid, out_id, out_flush);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL midflush_rst got v=%b busy=%b exp v=0 busy=0", out_valid, busy);
      end
      step();
      rst_n = 1'b1;
      req = 4'b1000; clr = '0; x[3*W +: W] = 32'd9;
      #1;
      n_checks++;
      if (gnt !== 4'b1000) begin n_fail++; $display("FAIL midflush_gnt got=%b exp=1000", gnt); end
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd3 || out_q !== 32'd9) begin
         n_fail++; $display("FAIL midflush_out got v=%b id=%0d q=%0d exp v=1 id=3 q=9", out_valid, out_id, out_q);
      end
      req = '0;
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_ptr_skip();
      test_load_wrap();
      test_flush();
      test_reset_mid_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/acc_rr_sched.md
Name: acc_rr_sched

Overview:
Shares one accumulator adder between N requesters. Each requester owns a private W-bit accumulation context.
- A round-robin arbiter grants one requester per cycle and updates that requester's context with the shared adder.
- A flush sequencer reads out and clears every context in order.
- Sits between the client request buses and the accumulate datapath. It replaces per-client accumulator instances.

Parameters:
N, 4, number of requesters/contexts (2..16)
W, 32, data and context width
IW, $clog2(N), width of requester index

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
req  in  N  per-requester request; held with x/clr until granted
clr  in  N  per-requester op select: 1 = load x into context, 0 = add x to context
x  in  N*W  per-requester operand, slice i = x[i*W +: W]
flush  in  1  single-cycle pulse: read out and zero all contexts
gnt  out  N  one-hot grant, combinational from req/state/pointer; request accepted in the cycle gnt[i]=1
out_valid  out  1  registered result strobe
out_id  out  IW  context index of the result
out_q  out  W  context value after the update (or flushed value)
out_flush  out  1  marks a result produced by the flush sequence
busy  out  1  1 while in FLUSH state

Behaviour:
- Reset (async, rst_n=0): all contexts 0; pointer 0; state RUN; out_valid=0, out_id=0, out_q=0, out_flush=0, busy=0; gnt=0 while in reset.
- States: RUN, FLUSH.
- RUN, arbitration:
  - Scan req starting at index ptr, wrapping modulo N. The first set bit i gets gnt[i]=1.
  - No req set: gnt=0 and ptr unchanged.
  - Exactly one gnt bit is ever high.
- RUN, update at the clock edge of a grant to i:
  - ctx[i] <= clr[i] ? x_i : ctx[i] + x_i, sum truncated modulo 2^W (carry discarded).
  - Same edge: out_valid<=1, out_id<=i, out_q<=new ctx[i], out_flush<=0.
  - ptr <= (i+1) mod N.
- Latency: result visible exactly one cycle after the grant cycle.
- Back-to-back grants to the same context are legal. Each uses the value written the previous cycle, with no stall.
- out_valid is a single-cycle pulse per grant. It is 0 in any cycle following a cycle with no grant and no flush output.
- flush=1 in RUN:
  - gnt=0 that cycle; flush has priority over req.
  - Next state FLUSH; flush counter fc=0.
  - ptr unchanged.
- FLUSH:
  - gnt=0; busy=1.
  - Each cycle: out_valid<=1, out_id<=fc, out_q<=ctx[fc], out_flush<=1; ctx[fc]<=0; fc++.
  - After fc=N-1 is emitted, return to RUN. The FLUSH entry cycle plus N cycles yields exactly N flush results, ids 0..N-1 ascending.
  - Requests arriving during FLUSH stay pending and are arbitrated in the first RUN cycle from the unchanged ptr.
- flush asserted while in FLUSH: ignored.
- Reset mid-FLUSH: immediate full reset. The flush is abandoned and all contexts are zeroed anyway.
- Requesters must hold req, clr and x stable until granted. Changing them before grant is undefined at the source side; the block samples them only in the grant cycle.

Test Plan:
- Single requester: N=4, req=0001, clr=0, x0=i for i=0..1337 held until each gnt. Expect out_q after grant k = k*(k+1)/2 mod 2^32, out_id=0, one result per cycle.
- Round-robin fairness: all req held high with x_i=i+1 for 8 grants. Expect gnt sequence 0,1,2,3,0,1,2,3. Final contexts 2,4,6,8.
- Pointer skip: ptr=2, req=1001. Expect gnt=1000 (idx 3), then gnt=0001, then ptr=1.
- Load vs add and wrap: ctx1 loaded with clr=1, x=FFFF_FFFE, then add x=3. Expect out_q=FFFF_FFFE then 0000_0001.
- Flush with contention:
  - Setup: contexts {5,6,7,8}; flush=1 while req=1111.
  - Expect gnt=0 for 5 cycles.
  - Flush results (id,q) = (0,5),(1,6),(2,7),(3,8) with out_flush=1 and busy=1.
  - Then grants resume from the unchanged ptr with contexts starting at 0.
- Async reset mid-flush: drop rst_n after 2 flush outputs. Expect out_valid=0 and busy=0 immediately. After release, a grant to idx 3 with clr=0, x=9 gives out_q=9.
